// File: rtl/cnna_udiv_16ns_15ns_13_seq.sv
// Sequential radix-2 restoring unsigned divider with a start/done/ready/idle handshake.
// One quotient bit is resolved per enabled clock; ce=0 freezes every register.
module cnna_udiv_16ns_15ns_13_seq #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = 16,
  parameter int          din1_WIDTH = 15,
  parameter int          dout_WIDTH = 13
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  div_zero
);

  localparam int K_W = $clog2(din0_WIDTH + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [din0_WIDTH-1:0]   q_q, q_d;
  logic [din1_WIDTH:0]     r_q, r_d;
  logic [din1_WIDTH-1:0]   d_q, d_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [dout_WIDTH-1:0]   dout_q, dout_d;
  logic [din1_WIDTH-1:0]   rem_q, rem_d;
  logic                    ovf_q, ovf_d;
  logic                    div_zero_q, div_zero_d;
  logic                    ap_done_q, ap_done_d;

  // ID only tags the instance; it has no functional effect.
  if (ID == 32'd0) begin : g_id_zero
  end

  // One restoring step. The borrow of the widened subtraction is the compare result;
  // R's top bit is only ever set for a zero divisor, where the step always subtracts 0.
  logic [din1_WIDTH+1:0]   t_w;
  logic [din1_WIDTH+1:0]   diff_w;
  logic                    ge_w;
  logic [din1_WIDTH:0]     r_step;
  logic [din0_WIDTH-1:0]   q_step;
  logic                    ovf_step;

  assign t_w    = {r_q, q_q[din0_WIDTH-1]};
  assign diff_w = t_w - {2'b00, d_q};
  assign ge_w   = ~diff_w[din1_WIDTH+1];
  assign r_step = ge_w ? diff_w[din1_WIDTH:0] : t_w[din1_WIDTH:0];
  assign q_step = {q_q[din0_WIDTH-2:0], ge_w};

  if (din0_WIDTH > dout_WIDTH) begin : g_ovf
    assign ovf_step = |q_step[din0_WIDTH-1:dout_WIDTH];
  end else begin : g_no_ovf
    assign ovf_step = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    r_d        = r_q;
    d_d        = d_q;
    k_d        = k_q;
    dout_d     = dout_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    div_zero_d = div_zero_q;
    ap_done_d  = ap_done_q;
    if (ce) begin
      ap_done_d = 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (ap_start) begin
            state_d = S_BUSY;
            q_d     = din0;
            d_d     = din1;
            r_d     = '0;
            k_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          q_d = q_step;
          r_d = r_step;
          k_d = k_q + K_W'(1);
          if (k_q == K_LAST) begin
            state_d    = S_DONE;
            dout_d     = q_step[dout_WIDTH-1:0];
            rem_d      = r_step[din1_WIDTH-1:0];
            ovf_d      = ovf_step;
            div_zero_d = (d_q == '0);
            ap_done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      k_q        <= '0;
      dout_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      div_zero_q <= 1'b0;
      ap_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      k_q        <= k_d;
      dout_q     <= dout_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      div_zero_q <= div_zero_d;
      ap_done_q  <= ap_done_d;
    end
  end

  assign ap_ready = (state_q != S_BUSY);
  assign ap_idle  = (state_q != S_BUSY);
  assign ap_done  = ap_done_q;
  assign dout     = dout_q;
  assign rem      = rem_q;
  assign ovf      = ovf_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_cnna_udiv_16ns_15ns_13_seq.sv
// Directed and random checks of the sequential divider against a plain-arithmetic model.
module tb_cnna_udiv_16ns_15ns_13_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        ap_start;
  logic [15:0] din0;
  logic [14:0] din1;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [12:0] dout;
  logic [14:0] rem;
  logic        ovf;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  cnna_udiv_16ns_15ns_13_seq #(
    .ID(32'd1), .din0_WIDTH(16), .din1_WIDTH(15), .dout_WIDTH(13)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .ap_start(ap_start),
    .din0(din0), .din1(din1), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .ap_done(ap_done), .dout(dout), .rem(rem), .ovf(ovf), .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [14:0] b,
                                output logic [12:0] q, output logic [14:0] r,
                                output logic o, output logic z);
    int unsigned full;
    if (b == 15'd0) begin
      q = '1;
      r = a[14:0];
      o = 1'b1;
      z = 1'b1;
    end else begin
      full = 32'(a) / 32'(b);
      q    = full[12:0];
      r    = 15'(32'(a) % 32'(b));
      o    = (full > 32'd8191);
      z    = 1'b0;
    end
  endfunction

  task automatic check_res(input string tag, input logic [15:0] a, input logic [14:0] b);
    logic [12:0] q;
    logic [14:0] r;
    logic        o, z;
    model(a, b, q, r, o, z);
    $display("txn %s: %0d / %0d -> dout=%0d rem=%0d ovf=%0d dz=%0d (model %0d r%0d)",
             tag, a, b, dout, rem, ovf, div_zero, q, r);
    check({tag, "_dout"}, 32'(dout), 32'(q));
    check({tag, "_rem"}, 32'(rem), 32'(r));
    check({tag, "_ovf"}, 32'(ovf), 32'(o));
    check({tag, "_divzero"}, 32'(div_zero), 32'(z));
  endtask

  // Present a request, let it pass the accept edge, then drive the follow-up inputs.
  task automatic start_op(input logic [15:0] a, input logic [14:0] b, input logic keep,
                          input logic [15:0] na, input logic [14:0] nb);
    @(negedge ap_clk);
    din0 = a; din1 = b; ap_start = 1'b1; ce = 1'b1;
    check("ready_before_accept", 32'(ap_ready), 32'd1);
    @(negedge ap_clk);
    ap_start = keep; din0 = na; din1 = nb;
    check("busy_not_idle", 32'(ap_idle), 32'd0);
  endtask

  // Count clock edges after the accept edge until ap_done, stalling ce on the requested edges.
  task automatic wait_done(input int stall_at, input int stall_len, output int n);
    n = 0;
    while (ap_done !== 1'b1 && n < 200) begin
      ce = !(n >= stall_at && n < stall_at + stall_len);
      @(negedge ap_clk);
      n++;
    end
    ce = 1'b1;
  endtask

  initial begin
    int          n;
    int          m;
    int          pulses;
    logic [15:0] ra;
    logic [14:0] rb;

    ap_rst = 1'b1; ce = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge ap_clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_divzero", 32'(div_zero), 32'd0);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_ready", 32'(ap_ready), 32'd1);
    ap_rst = 1'b0;

    // 1000/7 with latency and single-cycle done pulse
    start_op(16'd1000, 15'd7, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check("lat_1000_7", n, 16);
    check_res("d1000_7", 16'd1000, 15'd7);
    @(negedge ap_clk);
    check("done_one_cycle", 32'(ap_done), 32'd0);
    check("idle_after_done", 32'(ap_idle), 32'd1);

    start_op(16'd65000, 15'd13, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check("lat_65000_13", n, 16);
    check_res("d65000_13", 16'd65000, 15'd13);

    start_op(16'd52000, 15'd13, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check_res("d52000_13", 16'd52000, 15'd13);

    start_op(16'd65535, 15'd1, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check_res("d65535_1", 16'd65535, 15'd1);

    start_op(16'd65535, 15'd32767, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check_res("d65535_32767", 16'd65535, 15'd32767);

    start_op(16'd1234, 15'd0, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check("lat_div0", n, 16);
    check_res("d1234_0", 16'd1234, 15'd0);

    // back-to-back with ap_start held high through the busy phase
    start_op(16'd100, 15'd3, 1'b1, 16'd200, 15'd9);
    wait_done(-1, 0, n);
    check("lat_b2b_first", n, 16);
    check_res("b2b_100_3", 16'd100, 15'd3);
    check("b2b_ready_at_done", 32'(ap_ready), 32'd1);
    @(negedge ap_clk);
    ap_start = 1'b0; din0 = $urandom; din1 = $urandom;
    m = 1;
    check("b2b_done_fall", 32'(ap_done), 32'd0);
    while (ap_done !== 1'b1 && m < 200) begin
      @(negedge ap_clk);
      m++;
    end
    check("b2b_pulse_spacing", m, 17);
    check_res("b2b_200_9", 16'd200, 15'd9);

    // ce stalled for 5 cycles mid-division; ap_done holds through a stall after completion
    start_op(16'd1000, 15'd7, 1'b0, $urandom, $urandom);
    wait_done(5, 5, n);
    check("lat_stall", n, 21);
    check_res("stall_1000_7", 16'd1000, 15'd7);
    ce = 1'b0;
    @(negedge ap_clk);
    check("done_held_ce0", 32'(ap_done), 32'd1);
    ce = 1'b1;
    @(negedge ap_clk);
    check("done_fall_ce1", 32'(ap_done), 32'd0);

    // reset mid-division aborts without a done pulse
    start_op(16'd1000, 15'd7, 1'b0, $urandom, $urandom);
    repeat (8) @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_divzero", 32'(div_zero), 32'd0);
    check("abort_idle", 32'(ap_idle), 32'd1);
    check("abort_done", 32'(ap_done), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge ap_clk);
      if (ap_done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);

    start_op(16'd4321, 15'd17, 1'b0, $urandom, $urandom);
    wait_done(-1, 0, n);
    check("lat_after_abort", n, 16);
    check_res("after_abort", 16'd4321, 15'd17);

    // random operands, including small and zero divisors
    for (int t = 0; t < 24; t++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 15'd0;
        1, 2:    rb = 15'($urandom_range(1, 15));
        default: rb = 15'($urandom);
      endcase
      start_op(ra, rb, 1'b0, $urandom, $urandom);
      wait_done(-1, 0, n);
      check("lat_rand", n, 16);
      check_res("rand", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
